// File: rtl/ray_sphere_intersector.sv
// Single-sphere ray hit tester: one ray in flight, five-state FSM, exact 64-bit
// discriminant test, raster pixel counter with frame-done pulse.
module ray_sphere_intersector #(
  parameter int DIR_W = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ray_valid,
  output logic        ray_ready,
  input  logic [31:0] ray_dir_x,
  input  logic [31:0] ray_dir_y,
  input  logic [31:0] ray_dir_z,
  input  logic [10:0] camera_pos_x,
  input  logic [10:0] camera_pos_y,
  input  logic [10:0] camera_pos_z,
  input  logic [10:0] sphere_cx,
  input  logic [10:0] sphere_cy,
  input  logic [10:0] sphere_cz,
  input  logic [10:0] sphere_r,
  input  logic [12:0] image_width,
  input  logic [12:0] image_height,
  output logic        hit_valid,
  input  logic        hit_ready,
  output logic        hit,
  output logic [25:0] pixel_index,
  output logic        frame_done
);

  typedef enum logic [2:0] {S_IDLE, S_DOT, S_PRODUCT, S_DECIDE, S_OUTPUT} state_e;

  function automatic logic signed [63:0] sext_dir(input logic [31:0] v);
    return {{(64-DIR_W){v[DIR_W-1]}}, v[DIR_W-1:0]};
  endfunction

  function automatic logic signed [63:0] offset(input logic [10:0] p, input logic [10:0] q);
    logic signed [11:0] d;
    d = $signed({1'b0, p}) - $signed({1'b0, q});
    return {{52{d[11]}}, d};
  endfunction

  state_e state_q, state_d;
  logic   ready_q, hit_q, fd_q;
  logic [25:0] pix_q, cnt_q;

  logic signed [63:0] dx_q, dy_q, dz_q;
  logic [10:0] camx_q, camy_q, camz_q, sphx_q, sphy_q, sphz_q, r_q;
  logic signed [63:0] a_q, hb_q, c_q, p1_q, p2_q;

  logic signed [63:0] ocx, ocy, ocz, r64;
  logic signed [63:0] a_d, hb_d, c_d, disc;
  logic        hit_d, accept, out_hs, last_pix;
  logic [25:0] total;
  logic        dir_unused;

  // Only the low DIR_W bits of each direction component are significant.
  assign dir_unused = ^{ray_dir_x[31:DIR_W], ray_dir_y[31:DIR_W], ray_dir_z[31:DIR_W]};

  assign ocx  = offset(camx_q, sphx_q);
  assign ocy  = offset(camy_q, sphy_q);
  assign ocz  = offset(camz_q, sphz_q);
  assign r64  = {53'd0, r_q};
  assign a_d  = dx_q * dx_q + dy_q * dy_q + dz_q * dz_q;
  assign hb_d = ocx * dx_q + ocy * dy_q + ocz * dz_q;
  assign c_d  = ocx * ocx + ocy * ocy + ocz * ocz - r64 * r64;
  assign disc = p1_q - p2_q;
  // Real roots exist and at least one lies in front of the origin.
  assign hit_d = (disc >= 64'sd0) && ((hb_q < 64'sd0) || (c_q < 64'sd0));

  assign total    = {13'd0, image_width} * {13'd0, image_height};
  assign last_pix = (total == 26'd0) || (cnt_q >= total - 26'd1);
  assign accept   = (state_q == S_IDLE) && ready_q && ray_valid;
  assign out_hs   = (state_q == S_OUTPUT) && hit_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = S_DOT;
      S_DOT:     state_d = S_PRODUCT;
      S_PRODUCT: state_d = S_DECIDE;
      S_DECIDE:  state_d = S_OUTPUT;
      S_OUTPUT:  if (hit_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ready is registered so it stays low while reset is asserted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ready_q <= 1'b0;
      fd_q    <= 1'b0;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      fd_q    <= out_hs && last_pix;
      if (out_hs) cnt_q <= last_pix ? 26'd0 : cnt_q + 26'd1;
      if (state_q == S_DECIDE) begin
        hit_q <= hit_d;
        pix_q <= cnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dx_q <= '0; dy_q <= '0; dz_q <= '0;
      camx_q <= '0; camy_q <= '0; camz_q <= '0;
      sphx_q <= '0; sphy_q <= '0; sphz_q <= '0;
      r_q <= '0;
      a_q <= '0; hb_q <= '0; c_q <= '0;
      p1_q <= '0; p2_q <= '0;
    end else begin
      if (accept) begin
        dx_q   <= sext_dir(ray_dir_x);
        dy_q   <= sext_dir(ray_dir_y);
        dz_q   <= sext_dir(ray_dir_z);
        camx_q <= camera_pos_x;
        camy_q <= camera_pos_y;
        camz_q <= camera_pos_z;
        sphx_q <= sphere_cx;
        sphy_q <= sphere_cy;
        sphz_q <= sphere_cz;
        r_q    <= sphere_r;
      end
      if (state_q == S_DOT) begin
        a_q  <= a_d;
        hb_q <= hb_d;
        c_q  <= c_d;
      end
      if (state_q == S_PRODUCT) begin
        p1_q <= hb_q * hb_q;
        p2_q <= a_q * c_q;
      end
    end
  end

  assign ray_ready   = ready_q;
  assign hit_valid   = (state_q == S_OUTPUT);
  assign hit         = hit_q;
  assign pixel_index = pix_q;
  assign frame_done  = fd_q;

endmodule

// File: tb/tb_ray_sphere_intersector.sv
// Directed bench for ray_sphere_intersector: hand-computed hit results,
// latency, backpressure, async reset, frame wrap and zero-size frames.
module tb_ray_sphere_intersector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ray_valid;
  logic        ray_ready;
  logic [31:0] ray_dir_x, ray_dir_y, ray_dir_z;
  logic [10:0] camera_pos_x, camera_pos_y, camera_pos_z;
  logic [10:0] sphere_cx, sphere_cy, sphere_cz, sphere_r;
  logic [12:0] image_width, image_height;
  logic        hit_valid, hit_ready, hit, frame_done;
  logic [25:0] pixel_index;

  int n_assert = 0;
  int n_fail   = 0;
  int fd_cnt   = 0;

  ray_sphere_intersector #(.DIR_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .ray_valid(ray_valid), .ray_ready(ray_ready),
    .ray_dir_x(ray_dir_x), .ray_dir_y(ray_dir_y), .ray_dir_z(ray_dir_z),
    .camera_pos_x(camera_pos_x), .camera_pos_y(camera_pos_y), .camera_pos_z(camera_pos_z),
    .sphere_cx(sphere_cx), .sphere_cy(sphere_cy), .sphere_cz(sphere_cz), .sphere_r(sphere_r),
    .image_width(image_width), .image_height(image_height),
    .hit_valid(hit_valid), .hit_ready(hit_ready), .hit(hit),
    .pixel_index(pixel_index), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends one ray with hit_ready already high; returns result, latency and
  // frame_done as seen just after the result handshake.
  task automatic send_ray(input logic [31:0] dx, dy, dz,
                          input logic [10:0] cx, cy, cz, sx, sy, sz, r,
                          output logic h, output logic [25:0] pix,
                          output int lat, output logic fd);
    int k;
    @(negedge clk);
    k = 0;
    while (ray_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    chk("ready_timeout", 64'(k < 50), 64'd1);
    ray_dir_x = dx; ray_dir_y = dy; ray_dir_z = dz;
    camera_pos_x = cx; camera_pos_y = cy; camera_pos_z = cz;
    sphere_cx = sx; sphere_cy = sy; sphere_cz = sz; sphere_r = r;
    ray_valid = 1'b1;
    @(posedge clk); #1;
    ray_valid = 1'b0;
    ray_dir_x = $urandom(); ray_dir_y = $urandom(); ray_dir_z = $urandom();
    camera_pos_x = 11'($urandom()); camera_pos_z = 11'($urandom());
    sphere_cz = 11'($urandom()); sphere_r = 11'($urandom());
    lat = 0;
    while (hit_valid !== 1'b1 && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("result_timeout", 64'(lat < 50), 64'd1);
    h = hit; pix = pixel_index;
    @(posedge clk); #1;
    fd = frame_done;
  endtask

  initial begin
    logic h, h0, fd;
    logic [25:0] p, p0;
    int lat, bad, k, fd_base;

    reset_n = 1'b0; ray_valid = 1'b0; hit_ready = 1'b1;
    ray_dir_x = '0; ray_dir_y = '0; ray_dir_z = '0;
    camera_pos_x = '0; camera_pos_y = '0; camera_pos_z = '0;
    sphere_cx = '0; sphere_cy = '0; sphere_cz = '0; sphere_r = '0;
    image_width = 13'd640; image_height = 13'd480;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ray_ready", ray_ready, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit", hit, 0);
    chk("rst_pixel_index", pixel_index, 0);
    chk("rst_frame_done", frame_done, 0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", ray_ready, 1);

    // Head-on: a=2500 hb=-5000 c=9900, disc=250000
    send_ray(32'd0, 32'd0, 32'd50, 0, 0, 0, 0, 0, 100, 10, h, p, lat, fd);
    chk("headon_latency", lat, 3);
    chk("headon_hit", h, 1);
    chk("headon_pix", p, 0);
    // Miss: hb=-100, p2=2501*9900 >> p1
    send_ray(32'd50, 32'd0, 32'd1, 0, 0, 0, 0, 0, 100, 10, h, p, lat, fd);
    chk("miss_hit", h, 0);
    chk("miss_pix", p, 1);
    // Behind camera: disc>=0 but hb=+5000, c>0
    send_ray(32'd0, 32'd0, 32'hFFFF_FFCE, 0, 0, 0, 0, 0, 100, 10, h, p, lat, fd);
    chk("behind_hit", h, 0);
    chk("behind_pix", p, 2);
    // Tangent: disc exactly 0, upper dir bits are junk
    send_ray(32'd0, 32'd0, 32'hABCD_0001, 0, 0, 0, 10, 0, 100, 10, h, p, lat, fd);
    chk("tangent_hit", h, 1);
    // On the surface (c=0): forward hits, backward misses
    send_ray(32'd0, 32'd0, 32'd1, 0, 0, 0, 0, 0, 10, 10, h, p, lat, fd);
    chk("surface_fwd_hit", h, 1);
    send_ray(32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 10, 10, h, p, lat, fd);
    chk("surface_back_hit", h, 0);
    // Camera inside (c=-75), zero direction
    send_ray(32'd0, 32'd0, 32'd0, 100, 100, 100, 100, 100, 105, 10, h, p, lat, fd);
    chk("inside_d0_hit", h, 1);
    chk("inside_d0_pix", p, 6);
    // x=-32768: hb=-32768000, disc=2^30*10000>0
    send_ray(32'h7FFF_8000, 32'd0, 32'd0, 1000, 0, 0, 0, 0, 0, 100, h, p, lat, fd);
    chk("dirmin_hit", h, 1);
    chk("dirmin_pix", p, 7);
    chk("no_fd_midframe", fd, 0);

    // Backpressure with ray_valid held high
    @(negedge clk);
    ray_dir_x = 0; ray_dir_y = 0; ray_dir_z = 32'd50;
    camera_pos_x = 0; camera_pos_y = 0; camera_pos_z = 0;
    sphere_cx = 0; sphere_cy = 0; sphere_cz = 100; sphere_r = 10;
    hit_ready = 1'b0; ray_valid = 1'b1;
    k = 0;
    while (hit_valid !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    chk("bp_result_timeout", 64'(k < 50), 64'd1);
    h0 = hit; p0 = pixel_index;
    chk("bp_hit", h0, 1);
    chk("bp_pix", p0, 8);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ray_ready !== 1'b0 || hit_valid !== 1'b1 || hit !== h0 || pixel_index !== p0) bad++;
    end
    chk("bp_stable", bad, 0);
    @(negedge clk); hit_ready = 1'b1; ray_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_released_valid", hit_valid, 0);
    chk("bp_released_ready", ray_ready, 1);
    bad = 0;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (hit_valid !== 1'b0) bad++; end
    chk("bp_single_result", bad, 0);

    // Reset while a result is pending
    @(negedge clk);
    hit_ready = 1'b0; ray_valid = 1'b1; sphere_r = 10; sphere_cz = 100; ray_dir_z = 32'd50;
    @(posedge clk); #1; ray_valid = 1'b0;
    k = 0;
    while (hit_valid !== 1'b1 && k < 50) begin @(posedge clk); #1; k++; end
    chk("rst_mid_setup", hit_valid, 1);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_valid_async", hit_valid, 0);
    chk("rst_mid_pix", pixel_index, 0);
    @(negedge clk); reset_n = 1'b1; hit_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ready", ray_ready, 1);
    chk("rst_mid_pix_after", pixel_index, 0);

    // Frame wrap on a 3x2 image
    image_width = 13'd3; image_height = 13'd2;
    fd_base = fd_cnt;
    for (int i = 0; i < 7; i++) begin
      send_ray(32'd0, 32'd0, 32'd50, 0, 0, 0, 0, 0, 100, 10, h, p, lat, fd);
      chk($sformatf("wrap_pix_%0d", i), p, (i < 6) ? i : 0);
      chk($sformatf("wrap_fd_%0d", i), fd, (i == 5) ? 1 : 0);
    end
    chk("wrap_fd_count", fd_cnt - fd_base, 1);

    // Zero-width frame: every result handshake ends a frame
    image_width = 13'd0;
    send_ray(32'd0, 32'd0, 32'd50, 0, 0, 0, 0, 0, 100, 10, h, p, lat, fd);
    chk("w0_fd_first", fd, 1);
    send_ray(32'd0, 32'd0, 32'd50, 0, 0, 0, 0, 0, 100, 10, h, p, lat, fd);
    chk("w0_pix", p, 0);
    chk("w0_fd_second", fd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
